req_fork_join: RTL and testbench
================================

// Module: req_fork_join
// PURPOSE
//  Clocked fork/join sequencer. It launches one request pulse to up to REQ_NUMBER worker modules.
//  It then collects their asynchronous done-req rising edges and emits a one-cycle fin pulse once
//  every enabled worker has answered. It also flags a timeout if any worker fails to answer.
//  It sits upstream of the worker array. It is the synchronous counterpart of the async all-reqs
//  join and closes the loop between the control FSM and the workers.
// PARAMETERS
//  REQ_NUMBER     2     number of worker channels (>=1)
//  SYNC_STAGES    2     flops per reqs synchroniser (>=2)
//  TIMEOUT_CYCLES 1024  WAIT cycles before timeout; 0 disables timeout
//  CNT_W          16    width of roundCount
// PORTS
//  clk         in   1           single clock, all logic on posedge
//  rst_n       in   1           asynchronous, active-low reset
//  start       in   1           begin a round; sampled only in IDLE
//  mask        in   REQ_NUMBER  channels taking part in the round; captured with start
//  reqs        in   REQ_NUMBER  asynchronous done-reqs from the workers (rising edge = done)
//  launch      out  REQ_NUMBER  one-cycle request pulse to the enabled workers
//  busy        out  1           high from start accept until return to IDLE
//  fin         out  1           one-cycle pulse: all enabled workers done
//  timeout     out  1           sticky error flag; cleared at the next accepted start
//  pending     out  REQ_NUMBER  enabled channels not yet done
//  roundCount  out  CNT_W       completed rounds; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE.
//   - launch, busy, fin, timeout, pending, roundCount, synchroniser flops and edge-detect
//     history all go to 0.
//  Input conditioning:
//   - Each reqs[i] passes through SYNC_STAGES flops, then a previous-value flop.
//   - edge[i] = sync[i] & ~prev[i].
//   - A reqs rise sampled at edge e0 gives edge[i]=1 during the cycle after e0+SYNC_STAGES-1.
//  FSM states: IDLE, LAUNCH, WAIT, DONE, TOUT. Outputs are registered or decoded from state; glitch-free.
//   - IDLE: busy=0.
//     - start=1 & mask!=0: activeMask<=mask, pending<=mask, timeout<=0, timer<=0; -> LAUNCH.
//     - start=1 & mask==0: timeout<=0; -> DONE (no launch, fin still pulses).
//   - LAUNCH (1 cycle): launch=activeMask, busy=1; -> WAIT.
//     - Edges of active channels seen this cycle already clear pending.
//   - WAIT: busy=1.
//     - pending[i] clears on edge[i] & activeMask[i].
//     - Edges on inactive channels, or repeat edges on cleared channels, are ignored.
//     - When (pending & ~edge)==0: -> DONE.
//     - Otherwise timer++. If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: -> TOUT.
//     - Completion and timeout in the same cycle: completion wins.
//   - DONE (1 cycle): fin=1, busy=1, roundCount<=roundCount+1 (wraps); -> IDLE.
//   - TOUT (1 cycle): timeout<=1 (sticky), busy=1, no fin; pending keeps the missing channels; -> IDLE.
//  Latency:
//   - start sampled at edge s gives launch in cycle s+1.
//   - The last required reqs rise, sampled at e0, gives fin high in the cycle after edge
//     e0+SYNC_STAGES.
//  Boundaries:
//   - start while busy: ignored, never queued.
//   - mask changes after accept: no effect.
//   - reqs already high at start: no edge, so the channel waits for a fresh low->high transition.
//   - Reset mid-round: immediate return to IDLE with all outputs 0. No fin, no launch after release.
//   - A reqs level high at reset release produces an edge in IDLE; it is ignored.
// TESTING
//  1. REQ_NUMBER=2. mask=2'b11, start @c0 -> launch=2'b11 @c1.
//     reqs[0] rises @c5, reqs[1] rises @c9 -> fin for exactly one cycle @c12 (SYNC=2); roundCount 0->1.
//  2. mask=2'b01. Pulse reqs[1] repeatedly, never reqs[0]; TIMEOUT_CYCLES=8.
//     -> no fin; timeout=1 after 8 WAIT cycles; pending=2'b01; busy drops.
//  3. mask=2'b00, start -> no launch; fin pulse 1 cycle after the accept edge; roundCount+1.
//  4. Assert start every cycle while busy -> exactly one launch per round.
//     Next round's start clears timeout.
//  5. Drop rst_n in WAIT with pending=2'b10 -> outputs 0 asynchronously.
//     Raising reqs after release gives no fin.
//  6. CNT_W=2. Run 5 rounds -> roundCount sequence 1,2,3,0,1.
//     Completion on the timer-expiry cycle -> fin, timeout stays 0.

Source files
------------

// File: rtl/req_fork_join.sv
// rtl/req_fork_join.sv - clocked fork/join request sequencer with timeout
//
// Purpose:
//   Launches a one-cycle request pulse to the enabled workers of a round.
//   Collects their asynchronous done-req rising edges and pulses fin once
//   every enabled worker has answered. Flags a sticky timeout when a worker
//   stays silent for TIMEOUT_CYCLES cycles in WAIT.
//
// Parameters:
//   REQ_NUMBER     number of worker channels (>=1)
//   SYNC_STAGES    flops per reqs synchroniser (>=2)
//   TIMEOUT_CYCLES WAIT cycles before timeout; 0 disables the timeout
//   CNT_W          width of roundCount
//
// Ports:
//   clk         in   1           single clock, all logic on posedge
//   rst_n       in   1           asynchronous active-low reset
//   start       in   1           begin a round; sampled only in IDLE
//   mask        in   REQ_NUMBER  channels taking part; captured with start
//   reqs        in   REQ_NUMBER  asynchronous done-reqs (rising edge = done)
//   launch      out  REQ_NUMBER  one-cycle request pulse to enabled workers
//   busy        out  1           high from start accept until back in IDLE
//   fin         out  1           one-cycle pulse: all enabled workers done
//   timeout     out  1           sticky error flag; cleared by next accepted start
//   pending     out  REQ_NUMBER  enabled channels not yet done
//   roundCount  out  CNT_W       completed rounds, wraps modulo 2^CNT_W

module req_fork_join #(
  parameter int REQ_NUMBER     = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [REQ_NUMBER-1:0] mask,
  input  logic [REQ_NUMBER-1:0] reqs,
  output logic [REQ_NUMBER-1:0] launch,
  output logic                  busy,
  output logic                  fin,
  output logic                  timeout,
  output logic [REQ_NUMBER-1:0] pending,
  output logic [CNT_W-1:0]      roundCount
);

  // The timer only has to reach TIMEOUT_CYCLES-1, so clog2 bits are enough.
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMR_EN = (TIMEOUT_CYCLES != 0);
  localparam int TMR_LAST_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_LAST_INT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_TOUT   = 3'd4
  } state_t;

  state_t                                 state_q, state_d;
  logic [SYNC_STAGES-1:0][REQ_NUMBER-1:0] sync_q, sync_d;
  logic [REQ_NUMBER-1:0]                  prev_q, prev_d;
  logic [REQ_NUMBER-1:0]                  active_mask_q, active_mask_d;
  logic [REQ_NUMBER-1:0]                  pending_q, pending_d;
  logic                                   timeout_q, timeout_d;
  logic [TMR_W-1:0]                       timer_q, timer_d;
  logic [CNT_W-1:0]                       round_count_q, round_count_d;

  logic [REQ_NUMBER-1:0]                  req_sync;
  logic [REQ_NUMBER-1:0]                  req_edge;
  logic [REQ_NUMBER-1:0]                  pending_cleared;

  // ------------------------------------------------------------------
  // Input conditioning: shift register synchroniser, then a history flop
  // for rising-edge detection. Stage 0 samples the raw asynchronous input.
  // ------------------------------------------------------------------
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], reqs};
    req_sync = sync_q[SYNC_STAGES-1];
    prev_d   = req_sync;
    req_edge = req_sync & ~prev_q;
  end

  // Edges only count for channels of the current round; repeat edges on an
  // already-cleared channel fall out naturally because the bit is already 0.
  assign pending_cleared = pending_q & ~(req_edge & active_mask_q);

  // ------------------------------------------------------------------
  // State register and datapath flops
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sync_q        <= '0;
      prev_q        <= '0;
      active_mask_q <= '0;
      pending_q     <= '0;
      timeout_q     <= 1'b0;
      timer_q       <= '0;
      round_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      prev_q        <= prev_d;
      active_mask_q <= active_mask_d;
      pending_q     <= pending_d;
      timeout_q     <= timeout_d;
      timer_q       <= timer_d;
      round_count_q <= round_count_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state and datapath update
  // ------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    active_mask_d = active_mask_q;
    pending_d     = pending_q;
    timeout_d     = timeout_q;
    timer_d       = timer_q;
    round_count_d = round_count_q;

    unique case (state_q)
      ST_IDLE: begin
        // Edges arriving here (e.g. a level high at reset release) are
        // deliberately not looked at: pending only moves in LAUNCH/WAIT.
        if (start) begin
          timeout_d     = 1'b0;
          active_mask_d = mask;
          pending_d     = mask;
          timer_d       = '0;
          // An empty round still completes, it just skips the launch.
          state_d       = (mask != '0) ? ST_LAUNCH : ST_DONE;
        end
      end

      ST_LAUNCH: begin
        // A worker may already be answering while the launch is out.
        pending_d = pending_cleared;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        pending_d = pending_cleared;
        // Completion is tested before expiry so a last answer arriving on
        // the final timer cycle still finishes the round cleanly.
        if ((pending_q & ~req_edge) == '0) begin
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (TMR_EN && (timer_q == TMR_LAST)) begin
            state_d = ST_TOUT;
          end
        end
      end

      ST_DONE: begin
        round_count_d = round_count_q + CNT_W'(1);
        state_d       = ST_IDLE;
      end

      ST_TOUT: begin
        // pending keeps the silent channels for post-mortem inspection.
        timeout_d = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs: decoded from flops only, so no input-to-output paths.
  // ------------------------------------------------------------------
  assign launch     = (state_q == ST_LAUNCH) ? active_mask_q : '0;
  assign busy       = (state_q != ST_IDLE);
  assign fin        = (state_q == ST_DONE);
  assign timeout    = timeout_q;
  assign pending    = pending_q;
  assign roundCount = round_count_q;

endmodule

// File: tb/tb_req_fork_join.sv
// tb/tb_req_fork_join.sv - directed self-checking bench for req_fork_join

module tb_req_fork_join;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        start_a;
  logic [1:0]  mask_a, reqs_a, launch_a, pending_a;
  logic        busy_a, fin_a, timeout_a;
  logic [15:0] rc_a;

  logic        start_b;
  logic [1:0]  mask_b, reqs_b, launch_b, pending_b;
  logic        busy_b, fin_b, timeout_b;
  logic [1:0]  rc_b;

  req_fork_join #(
    .REQ_NUMBER(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(1024), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mask(mask_a), .reqs(reqs_a),
    .launch(launch_a), .busy(busy_a), .fin(fin_a), .timeout(timeout_a),
    .pending(pending_a), .roundCount(rc_a)
  );

  req_fork_join #(
    .REQ_NUMBER(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(8), .CNT_W(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mask(mask_b), .reqs(reqs_b),
    .launch(launch_b), .busy(busy_b), .fin(fin_b), .timeout(timeout_b),
    .pending(pending_b), .roundCount(rc_b)
  );

  typedef struct {
    logic        start;
    logic [1:0]  mask;
    logic [1:0]  reqs;
    logic [1:0]  launch;
    logic        busy;
    logic        fin;
    logic [1:0]  pending;
    logic        timeout;
    logic [15:0] rc;
  } vec_t;

  vec_t vecs[17];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nl, nf, nb;
    bit found;
    int rc_seq[5];
    rc_seq = '{1, 2, 3, 0, 1};

    // Row = one cycle on u_a: inputs driven in that cycle, outputs seen in it.
    //                start  mask   reqs   launch busy  fin   pend   tout  rc
    vecs[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 16'd0};
    vecs[12] = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 16'd0};
    vecs[13] = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 16'd1};
    vecs[14] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 16'd1};
    vecs[15] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 16'd1};
    vecs[16] = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 16'd2};

    rst_n   = 1'b0;
    start_a = 1'b0; mask_a = 2'b00; reqs_a = 2'b00;
    start_b = 1'b0; mask_b = 2'b00; reqs_b = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {launch_a, busy_a, fin_a, timeout_a, pending_a, rc_a}, 32'd0);
    check("reset_b", {launch_b, busy_b, fin_b, timeout_b, pending_b, rc_b}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Basic round, mask change / start while busy, then empty-mask round.
    for (int i = 0; i < 17; i++) begin
      start_a = vecs[i].start;
      mask_a  = vecs[i].mask;
      reqs_a  = vecs[i].reqs;
      check($sformatf("vec%0d", i),
            {launch_a, busy_a, fin_a, pending_a, timeout_a, rc_a},
            {vecs[i].launch, vecs[i].busy, vecs[i].fin, vecs[i].pending,
             vecs[i].timeout, vecs[i].rc});
      step();
    end

    // start held high through a whole round: exactly one launch.
    start_a = 1'b1; mask_a = 2'b11; reqs_a = 2'b00;
    nl = 0; nf = 0;
    repeat (8) begin
      step();
      if (launch_a != 2'b00) nl++;
      if (fin_a) nf++;
    end
    check("held_start_launch", nl, 1);
    check("held_start_nofin", nf, 0);
    reqs_a = 2'b11;
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (launch_a != 2'b00) nl++;
      if (fin_a) begin
        found   = 1'b1;
        start_a = 1'b0;
        break;
      end
    end
    check("held_start_fin_seen", found, 1);
    check("held_start_launch_total", nl, 1);
    step();
    step();
    check("held_start_rc_idle", {busy_a, rc_a}, {1'b0, 16'd3});
    reqs_a = 2'b00;

    // Five rounds on the 2-bit counter: 1,2,3,0,1.
    for (int r = 0; r < 5; r++) begin
      start_b = 1'b1; mask_b = 2'b11;
      step();
      start_b = 1'b0;
      repeat (3) step();
      reqs_b = 2'b11;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (fin_b) begin
          found = 1'b1;
          break;
        end
      end
      check($sformatf("wrap_fin%0d", r), found, 1);
      step();
      check($sformatf("wrap_rc%0d", r), rc_b, rc_seq[r]);
      reqs_b = 2'b00;
      repeat (3) step();
    end

    // Completion lands on the last timer cycle: fin wins, no timeout.
    start_b = 1'b1; mask_b = 2'b01; reqs_b = 2'b00;
    step();
    start_b = 1'b0;
    repeat (6) step();
    reqs_b = 2'b01;
    step();
    step();
    check("expiry_still_wait", {busy_b, fin_b}, 2'b10);
    step();
    check("expiry_fin", {fin_b, timeout_b}, 2'b10);
    step();
    check("expiry_after", {busy_b, timeout_b, rc_b}, {1'b0, 1'b0, 2'd2});
    reqs_b = 2'b00;
    repeat (3) step();

    // Timeout: only the inactive channel toggles.
    start_b = 1'b1; mask_b = 2'b01;
    step();
    start_b = 1'b0;
    nb = 0; nf = 0;
    for (int k = 0; k < 14; k++) begin
      if (busy_b) nb++;
      if (fin_b) nf++;
      reqs_b = {~reqs_b[1], 1'b0};
      step();
    end
    check("tout_busy_cycles", nb, 10);
    check("tout_nofin", nf, 0);
    check("tout_flags", {timeout_b, pending_b, busy_b}, {1'b1, 2'b01, 1'b0});
    reqs_b = 2'b00;
    repeat (3) step();
    start_b = 1'b1; mask_b = 2'b10;
    step();
    start_b = 1'b0;
    check("tout_cleared", {timeout_b, launch_b}, {1'b0, 2'b10});
    reqs_b = 2'b10;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (fin_b) begin
        found = 1'b1;
        break;
      end
    end
    check("tout_next_round_fin", found, 1);

    // Reset mid-round with channel 1 still outstanding.
    start_a = 1'b1; mask_a = 2'b11; reqs_a = 2'b00;
    step();
    start_a = 1'b0;
    step();
    reqs_a = 2'b01;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (pending_a == 2'b10) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_pending10", found, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {launch_a, busy_a, fin_a, timeout_a, pending_a, rc_a}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    reqs_a = 2'b11;
    nl = 0; nf = 0; nb = 0;
    repeat (12) begin
      step();
      if (launch_a != 2'b00) nl++;
      if (fin_a) nf++;
      if (busy_a) nb++;
    end
    check("rst_after_nofin", nf, 0);
    check("rst_after_nolaunch", nl, 0);
    check("rst_after_idle", nb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
